// File: rtl/uart_tx_if.sv
// Core-side UART data/CSR signals grouped for the transmitter.
interface uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            wen;
    logic [7:0]      wdata;
    logic            clr_ovf;
    logic            tx;
    logic            busy;
    logic            full;
    logic [CntW-1:0] count;
    logic            overflow;

    modport master (
        output wen, wdata, clr_ovf,
        input  tx, busy, full, count, overflow
    );

    modport slave (
        input  wen, wdata, clr_ovf,
        output tx, busy, full, count, overflow
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; LSB first, line idles high.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem [FIFO_DEPTH];

    logic full;
    logic push;
    logic pop;
    logic bit_end;

    // Push is decided from pre-edge fullness; a same-cycle pop never rescues a write.
    assign full    = (count_q == CntFull);
    assign push    = bus.wen && !full;
    assign bit_end = (baud_q == BaudMax);

    // FIFO storage; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wdata;
        end
    end

    // Next-state, pop decision and registered line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
        endcase

        // Line level is derived from the next state so tx_q is glitch-free.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Occupancy and sticky overflow next-state.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        ovf_d = ovf_q;
        if (bus.wen && full) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset forces the line high without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state_q != StIdle) || (count_q != '0);
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;
    localparam int unsigned Cpb = 4;
    localparam int unsigned Depth = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    uart_tx_if #(.FIFO_DEPTH(Depth)) bus ();

    uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        bus.wen   = 1'b1;
        bus.wdata = b;
        tick();
        bus.wen   = 1'b0;
    endtask

    // Checks every cycle of a frame from cycle index 'first' (0 = first start cycle).
    task automatic check_frame(input logic [7:0] b, input int first);
        logic exp;
        for (int c = first; c < 10 * Cpb; c++) begin
            if (c < Cpb) begin
                exp = 1'b0;
            end else if (c < 9 * Cpb) begin
                exp = b[c / Cpb - 1];
            end else begin
                exp = 1'b1;
            end
            check($sformatf("tx b=%02h c=%0d", b, c), {31'd0, bus.tx}, {31'd0, exp});
            tick();
        end
    endtask

    // Counts cycles with tx low over a quiet window.
    task automatic check_quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.tx !== 1'b1) lows++;
            tick();
        end
        check(tag, lows, 0);
    endtask

    initial begin
        logic [7:0] v;
        int         n;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        bus.wen     = 1'b0;
        bus.wdata   = 8'h00;
        bus.clr_ovf = 1'b0;
        tick();
        tick();
        check("rst_tx", {31'd0, bus.tx}, 1);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_full", {31'd0, bus.full}, 0);
        check("rst_count", {29'd0, bus.count}, 0);
        check("rst_ovf", {31'd0, bus.overflow}, 0);
        #2 rst = 1'b1;
        tick();

        // Single byte
        write(8'h55);
        check("s_count1", {29'd0, bus.count}, 1);
        check("s_busy1", {31'd0, bus.busy}, 1);
        check("s_tx_pre", {31'd0, bus.tx}, 1);
        tick();
        check("s_count0", {29'd0, bus.count}, 0);
        check_frame(8'h55, 0);
        check("s_busy_end", {31'd0, bus.busy}, 0);
        check_quiet("s_quiet", 8);

        // Back-to-back: second push coincides with the first pop
        write(8'hA5);
        check("b_count_a", {29'd0, bus.count}, 1);
        write(8'h0F);
        check("b_count_b", {29'd0, bus.count}, 1);
        check_frame(8'hA5, 0);
        check("b_count_c", {29'd0, bus.count}, 0);
        check_frame(8'h0F, 0);
        check("b_busy_end", {31'd0, bus.busy}, 0);
        check_quiet("b_quiet", 4);

        // Overflow and set-over-clear
        write(8'h11);
        tick();
        check("o_count0", {29'd0, bus.count}, 0);
        write(8'h21);
        write(8'h22);
        write(8'h23);
        write(8'h24);
        check("o_full", {31'd0, bus.full}, 1);
        check("o_count4", {29'd0, bus.count}, 4);
        check("o_ovf_pre", {31'd0, bus.overflow}, 0);
        write(8'h25);
        check("o_ovf_set", {31'd0, bus.overflow}, 1);
        check("o_count_keep", {29'd0, bus.count}, 4);
        bus.clr_ovf = 1'b1;
        write(8'h26);
        bus.clr_ovf = 1'b0;
        check("o_set_wins", {31'd0, bus.overflow}, 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("o_clr", {31'd0, bus.overflow}, 0);
        check_frame(8'h11, 7);
        check_frame(8'h21, 0);
        check_frame(8'h22, 0);
        check_frame(8'h23, 0);
        check_frame(8'h24, 0);
        check("o_busy_end", {31'd0, bus.busy}, 0);
        check_quiet("o_no_extra", 50);

        // Reset mid-frame during data bit 3 with two bytes queued
        write(8'hC3);
        tick();
        write(8'h77);
        write(8'h88);
        check("r_count2", {29'd0, bus.count}, 2);
        repeat (15) tick();
        check("r_tx_bit3", {31'd0, bus.tx}, 0);
        #2 rst = 1'b0;
        #1;
        check("r_tx_async", {31'd0, bus.tx}, 1);
        check("r_count", {29'd0, bus.count}, 0);
        check("r_busy", {31'd0, bus.busy}, 0);
        check("r_full", {31'd0, bus.full}, 0);
        #2 rst = 1'b1;
        tick();
        check_quiet("r_quiet", 50);
        check("r_busy_after", {31'd0, bus.busy}, 0);

        // Wrap-around: 0x01..0x0A in bursts of 3, 3, 3, 1
        v = 8'h01;
        for (int k = 0; k < 4; k++) begin
            n = (k == 3) ? 1 : 3;
            for (int i = 0; i < n; i++) begin
                write(v + 8'(i));
            end
            if (n == 1) tick();
            for (int i = 0; i < n; i++) begin
                check_frame(v + 8'(i), (i == 0 && n > 1) ? n - 2 : 0);
            end
            check($sformatf("w_busy_end k=%0d", k), {31'd0, bus.busy}, 0);
            v = v + 8'(n);
            tick();
        end
        check_quiet("w_quiet", 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
